except_ctrl: RTL and testbench

- Pipeline exception and interrupt sequencer for the five-stage core.
- Synchronises external interrupt lines and merges the timer interrupt before they reach the CP0 register file's int_i input.
- Raises a registered interrupt request to the mem stage when CP0 Status/Cause permit.
- On a committed exception code from the mem stage, runs a flush/redirect FSM that drives flush, new PC and the per-stage stall vector.

---
 rtl/except_ctrl.sv | 129 ++++++++++++
 tb/tb_except_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: syncs interrupt lines, raises int_req,
// and runs the flush/redirect FSM on committed exception codes.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic [5:0]       int_i,
    input  logic             timer_int_i,
    output logic [5:0]       int_sync_o,
    output logic             int_req_o,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] exc_count_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state_q;
    logic [5:0]       sync1_q, sync2_q;
    logic             timer_q;
    logic             int_req_q;
    logic             flush_q;
    logic             busy_q;
    logic [31:0]      new_pc_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             irq_cond;
    logic             unused_bits;

    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                           cp0_cause_i[31:16], cp0_cause_i[7:0]};

    always_comb begin
        accept = 1'b0;
        case (excepttype_i)
            32'h01, 32'h08, 32'h0a,
            32'h0c, 32'h0d, 32'h0e: accept = 1'b1;
            default:                accept = 1'b0;
        endcase
    end

    assign irq_cond = cp0_status_i[0] & ~cp0_status_i[1]
                    & |(cp0_cause_i[15:8] & cp0_status_i[15:8]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            timer_q <= 1'b0;
        end else begin
            sync1_q <= int_i;
            sync2_q <= sync1_q;
            timer_q <= timer_int_i;
        end
    end

    // int_req is cleared on the same edge that enters FLUSH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
            new_pc_q  <= '0;
            fcnt_q    <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= FLUSH;
                        int_req_q <= 1'b0;
                        flush_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        new_pc_q  <= (excepttype_i == 32'h0e) ? cp0_epc_i
                                                              : EXC_VECTOR;
                        fcnt_q    <= 3'(FLUSH_CYCLES - 1);
                        if (!(&cnt_q))
                            cnt_q <= cnt_q + 1'b1;
                    end else begin
                        int_req_q <= irq_cond;
                    end
                end
                FLUSH: begin
                    if (fcnt_q == 3'd0) begin
                        state_q   <= IDLE;
                        int_req_q <= irq_cond;
                        flush_q   <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        fcnt_q    <= fcnt_q - 3'd1;
                        int_req_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 6'b000000;
        if (state_q == FLUSH)
            stall_o = 6'b000000;
        else if (stallreq_ex_i)
            stall_o = 6'b001111;
        else if (stallreq_id_i)
            stall_o = 6'b000111;
    end

    assign int_sync_o  = {sync2_q[5] | timer_q, sync2_q[4:0]};
    assign int_req_o   = int_req_q;
    assign flush_o     = flush_q;
    assign busy_o      = busy_q;
    assign new_pc_o    = new_pc_q;
    assign exc_count_o = cnt_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench: u1 uses one flush cycle and a 4-bit counter,
// u3 uses three flush cycles and the default counter width.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sid, sex;
    logic [31:0] ex1, ex3;
    logic [31:0] status, cause, epc;
    logic [5:0]  intl;
    logic        timer;

    logic [5:0]  sync1, sync3, stall1, stall3;
    logic        req1, req3, fl1, fl3, busy1, busy3;
    logic [31:0] pc1, pc3;
    logic [3:0]  cnt1;
    logic [15:0] cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    except_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst),
        .stallreq_id_i(sid), .stallreq_ex_i(sex),
        .excepttype_i(ex1), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc),
        .int_i(intl), .timer_int_i(timer),
        .int_sync_o(sync1), .int_req_o(req1), .stall_o(stall1),
        .flush_o(fl1), .new_pc_o(pc1), .busy_o(busy1),
        .exc_count_o(cnt1)
    );

    except_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst),
        .stallreq_id_i(sid), .stallreq_ex_i(sex),
        .excepttype_i(ex3), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc),
        .int_i(intl), .timer_int_i(timer),
        .int_sync_o(sync3), .int_req_o(req3), .stall_o(stall3),
        .flush_o(fl3), .new_pc_o(pc3), .busy_o(busy3),
        .exc_count_o(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sid = 1'b0; sex = 1'b0;
        ex1 = '0; ex3 = '0; status = '0; cause = '0; epc = '0;
        intl = '0; timer = 1'b0;
        // reset state
        intl = 6'b111111; timer = 1'b1; status = 32'h1000FF01;
        cause = 32'h400; ex1 = 32'h08;
        step(); step();
        chk("rst_sync", 32'(sync1), 32'h0);
        chk("rst_req", 32'(req1), 32'h0);
        chk("rst_flush", 32'(fl1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_pc", pc1, 32'h0);
        chk("rst_cnt", 32'(cnt1), 32'h0);
        intl = '0; timer = 1'b0; status = '0; cause = '0; ex1 = '0;
        step();
        rst = 1'b0;
        step(); step();

        // two-flop sync latency and timer merge
        intl = 6'b000001;
        step();
        chk("sync_lat1", 32'(sync1), 32'h0);
        step();
        chk("sync_lat2", 32'(sync1), 32'h01);
        timer = 1'b1;
        step();
        chk("sync_timer", 32'(sync3), 32'h21);
        timer = 1'b0; intl = '0;
        step();
        chk("sync_timer_off", 32'(sync3), 32'h01);

        // interrupt request gating
        status = 32'h1000FF01; cause = 32'h00000400;
        #1;
        chk("req_before", 32'(req1), 32'h0);
        step();
        chk("req_on", 32'(req1), 32'h1);
        status = 32'h1000FF03;
        step();
        chk("req_exl", 32'(req1), 32'h0);
        status = 32'h1000FF01;
        step();
        chk("req_again", 32'(req1), 32'h1);

        // syscall on u1 with interrupt pending
        ex1 = 32'h08;
        step();
        chk("sys_flush", 32'(fl1), 32'h1);
        chk("sys_pc", pc1, 32'h20);
        chk("sys_busy", 32'(busy1), 32'h1);
        chk("sys_cnt", 32'(cnt1), 32'h1);
        chk("sys_req_off", 32'(req1), 32'h0);
        chk("u3_req_on", 32'(req3), 32'h1);
        ex1 = '0;
        step();
        chk("sys_flush_end", 32'(fl1), 32'h0);
        chk("sys_busy_end", 32'(busy1), 32'h0);
        chk("sys_pc_hold", pc1, 32'h20);
        chk("sys_req_back", 32'(req1), 32'h1);
        status = '0; cause = '0;

        // ERET on u3, three flush cycles, second code ignored
        epc = 32'h00001234; ex3 = 32'h0e;
        step();
        ex3 = 32'h08; epc = 32'h00005555;
        chk("eret_f1", 32'(fl3), 32'h1);
        chk("eret_pc", pc3, 32'h1234);
        chk("eret_cnt", 32'(cnt3), 32'h1);
        step();
        chk("eret_f2", 32'(fl3), 32'h1);
        step();
        chk("eret_f3", 32'(fl3), 32'h1);
        ex3 = '0;
        step();
        chk("eret_f4", 32'(fl3), 32'h0);
        chk("eret_busy", 32'(busy3), 32'h0);
        chk("eret_pc_hold", pc3, 32'h1234);
        step();
        chk("eret_no_refl", 32'(fl3), 32'h0);
        chk("eret_cnt_once", 32'(cnt3), 32'h1);

        // stall priority and exception with stalls
        sid = 1'b1; sex = 1'b1;
        #1;
        chk("stall_ex", 32'(stall1), 32'h0F);
        sex = 1'b0;
        #1;
        chk("stall_id", 32'(stall1), 32'h07);
        sex = 1'b1; ex1 = 32'h0a;
        #1;
        chk("stall_same_cyc", 32'(stall1), 32'h0F);
        step();
        chk("stall_in_flush", 32'(stall1), 32'h0);
        chk("inv_flush", 32'(fl1), 32'h1);
        chk("inv_cnt", 32'(cnt1), 32'h2);
        ex1 = '0;
        step();
        chk("stall_after", 32'(stall1), 32'h0F);
        sid = 1'b0; sex = 1'b0;
        #1;
        chk("stall_none", 32'(stall1), 32'h0);

        // unsupported code ignored
        ex1 = 32'h05;
        step();
        chk("bad_flush", 32'(fl1), 32'h0);
        step();
        chk("bad_cnt", 32'(cnt1), 32'h2);
        ex1 = '0;

        // counter saturation on the 4-bit instance
        ex1 = 32'h01;
        repeat (40) step();
        ex1 = '0;
        step(); step();
        chk("sat_cnt", 32'(cnt1), 32'hF);
        chk("sat_pc", pc1, 32'h20);

        // reset mid-flush aborts at once
        ex3 = 32'h0c;
        step();
        ex3 = '0;
        chk("ovf_flush", 32'(fl3), 32'h1);
        chk("ovf_cnt", 32'(cnt3), 32'h2);
        rst = 1'b1;
        #1;
        chk("abort_flush", 32'(fl3), 32'h0);
        chk("abort_busy", 32'(busy3), 32'h0);
        chk("abort_cnt", 32'(cnt3), 32'h0);
        chk("abort_pc", pc3, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("abort_idle", 32'(fl3), 32'h0);
        chk("abort_idle_b", 32'(busy3), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
